// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the data-memory bus.
// Latched transactions, variable-wait slave, wait-timeout watchdog.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ready_i,
  output logic              core_hold_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LP_LAST =
    CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] LP_MAX = '1;

  state_t            r_state;
  logic              r_last;
  logic              r_gnt;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_en;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_m0_ack;
  logic              r_m0_err;
  logic [DATA_W-1:0] r_m0_rdata;
  logic              r_m1_ack;
  logic              r_m1_err;
  logic [DATA_W-1:0] r_m1_rdata;

  logic              w_any;
  logic              w_gnt1;
  logic              w_tmo;
  logic [DATA_W-1:0] w_rd;

  // Master 1 wins when alone, or on contention when master 0 went last.
  assign w_any  = m0_req_i | m1_req_i;
  assign w_gnt1 = m1_req_i & (~m0_req_i | ~r_last);
  assign w_tmo  = (TIMEOUT != 0) && (r_cnt == LP_LAST);
  assign w_rd   = r_we ? '0 : mem_rdata_i;

  // Arbitration FSM with registered slave and master outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_last     <= 1'b1;
      r_gnt      <= 1'b0;
      r_cnt      <= '0;
      r_en       <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_m0_ack   <= 1'b0;
      r_m0_err   <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_ack   <= 1'b0;
      r_m1_err   <= 1'b0;
      r_m1_rdata <= '0;
    end else begin
      r_m0_ack   <= 1'b0;
      r_m0_err   <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_ack   <= 1'b0;
      r_m1_err   <= 1'b0;
      r_m1_rdata <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_gnt1;
            r_last  <= w_gnt1;
            r_we    <= w_gnt1 ? m1_we_i : m0_we_i;
            r_addr  <= w_gnt1 ? m1_addr_i : m0_addr_i;
            r_wdata <= w_gnt1 ? m1_wdata_i : m0_wdata_i;
            r_en    <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (mem_ready_i || w_tmo) begin
            r_en    <= 1'b0;
            r_state <= S_DONE;
            if (r_gnt) begin
              r_m1_ack   <= 1'b1;
              r_m1_err   <= ~mem_ready_i;
              r_m1_rdata <= mem_ready_i ? w_rd : '0;
            end else begin
              r_m0_ack   <= 1'b1;
              r_m0_err   <= ~mem_ready_i;
              r_m0_rdata <= mem_ready_i ? w_rd : '0;
            end
          end else if (r_cnt != LP_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_en_o    = r_en;
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign m0_ack_o    = r_m0_ack;
  assign m0_err_o    = r_m0_err;
  assign m0_rdata_o  = r_m0_rdata;
  assign m1_ack_o    = r_m1_ack;
  assign m1_err_o    = r_m1_err;
  assign m1_rdata_o  = r_m1_rdata;
  assign core_hold_o = m0_req_i & ~r_m0_ack;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the data-memory bus. It shares a single memory port between the core load/store path (master 0) and a debug/DMA master (master 1).
- Fair round-robin grant, latched transactions, a variable-wait slave handshake and a wait-timeout watchdog.
- Drives a hold request to the pipeline controller while a core access is outstanding, so EX/MEM can stall.

Parameters:
- ADDR_W, 32, address width of masters and slave.
- DATA_W, 32, data width of masters and slave.
- TIMEOUT, 16, maximum ACCESS cycles waiting for mem_ready_i before abort; 0 disables the watchdog.
- CNT_W, 8, width of the timeout counter; must satisfy TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- m0_req_i  in  1  master 0 (core) request, level; held until m0_ack_o.
- m0_we_i  in  1  master 0 write enable (1 = write, 0 = read).
- m0_addr_i  in  ADDR_W  master 0 address.
- m0_wdata_i  in  DATA_W  master 0 write data.
- m0_rdata_o  out  DATA_W  master 0 read data; valid while m0_ack_o = 1.
- m0_ack_o  out  1  master 0 completion pulse, one cycle.
- m0_err_o  out  1  master 0 timeout error; valid with m0_ack_o.
- m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_rdata_o, m1_ack_o, m1_err_o: same as m0_*, for master 1.
- mem_en_o  out  1  slave access strobe.
- mem_we_o  out  1  slave write enable.
- mem_addr_o  out  ADDR_W  slave address.
- mem_wdata_o  out  DATA_W  slave write data.
- mem_rdata_i  in  DATA_W  slave read data; sampled when mem_ready_i = 1.
- mem_ready_i  in  1  slave completion; ignored unless state is ACCESS.
- core_hold_o  out  1  stall request to the pipeline controller.

Behaviour:
- Reset (synchronous, rst = 1 at a rising edge):
  - state = IDLE; all *_o registers = 0; timeout counter = 0.
  - last_grant = 1, so master 0 wins the first contention.
  - Reset mid-ACCESS abandons the transaction: mem_en_o = 0 after that edge, no ack issued.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one req: grant that master.
  - Both req: grant the master != last_grant.
  - On grant, latch we/addr/wdata, set gnt_id and last_grant = gnt_id, go to ACCESS.
  - Request sampled at edge T: mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o valid from T+1.
- ACCESS:
  - mem_en_o = 1; slave outputs are driven from latched values, and master input changes are ignored.
  - mem_ready_i = 1: capture mem_rdata_i (reads only; writes return rdata 0), err = 0, go to DONE.
  - Else, if TIMEOUT != 0 and counter == TIMEOUT-1: err = 1, rdata = 0, go to DONE.
  - Else counter++.
  - Ready and timeout in the same cycle: ready wins, err = 0.
- DONE, one cycle:
  - mem_en_o = 0; granted mX_ack_o = 1 with mX_rdata_o/mX_err_o; counter cleared; go to IDLE.
  - Requests are not sampled in DONE. A req still high in the following IDLE cycle is a new transaction.
- Minimum transaction: grant edge T, ACCESS T+1 with immediate ready, ack at T+2 → 3 cycles, so 1 transaction per 3 cycles max.
- rdata/err hold 0 outside ack cycles. The non-granted master's ack/err never assert.
- core_hold_o = m0_req_i & ~m0_ack_o (combinational). It stays high while master 0 waits for grant or access.
- Round-robin fairness: under continuous contention grants alternate 0,1,0,1…; no master waits more than one foreign transaction.
- Counter saturates at TIMEOUT-1 and never wraps.
- mem_ready_i asserted outside ACCESS has no effect.

Test Plan:
- Single read: m0 read addr 0x100, slave ready on first ACCESS cycle with rdata 0xDEADBEEF → mem_en_o high 1 cycle; m0_ack_o at grant+2 with m0_rdata_o = 0xDEADBEEF, m0_err_o = 0; core_hold_o high for 2 cycles.
- Contention: m0 and m1 both request from reset and hold req continuously, ready immediate each access → grant order 0,1,0,1; acks every 3 cycles alternating; m1 write of 0x55AA to 0x200 appears on mem_addr_o/mem_wdata_o.
- Wait states: m1 read, ready after 5 ACCESS cycles with rdata 0x12345678 → mem_en_o high exactly 5 cycles; m1_ack_o one cycle after; master address change mid-access does not alter mem_addr_o.
- Timeout: TIMEOUT = 4, ready never asserted → mem_en_o high 4 cycles, then m0_ack_o = 1, m0_err_o = 1, m0_rdata_o = 0; next request proceeds normally.
- Ready and timeout coincide on cycle 4 → err = 0, data captured.
- Reset mid-ACCESS: rst = 1 on cycle 2 of a wait → next edge all outputs 0, no ack; after release, first contention grants m0.
